// File: rtl/mmio_bridge_if.sv
// CPU data-side bus between the MEM stage and mmio_bridge.
// The CPU drives address, store data and the store strobe; load data returns combinationally.
interface mmio_bridge_if;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_we;
    logic [31:0] cpu_rdata;

    modport master (
        output cpu_addr,
        output cpu_wdata,
        output cpu_we,
        input  cpu_rdata
    );

    modport slave (
        input  cpu_addr,
        input  cpu_wdata,
        input  cpu_we,
        output cpu_rdata
    );
endinterface

// File: rtl/mmio_bridge.sv
// Routes CPU data accesses to RAM (addr[31]=0) or to MMIO: 8N1 UART TX, machine timer, LED register.
// Define MMIO_TIMER_EN to build the MTIME/MTIMECMP timer and timer_irq; otherwise they read 0.
module mmio_bridge #(
    parameter int RAM_AW  = 10,
    parameter int CLK_DIV = 868
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    mmio_bridge_if.slave      bus,
    output logic [RAM_AW-1:0] o_ram_addr,
    output logic [31:0]       o_ram_wdata,
    output logic              o_ram_we,
    input  logic [31:0]       i_ram_rdata,
    output logic              o_uart_tx,
    output logic              o_timer_irq,
    output logic [7:0]        o_led
);

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_t;

    localparam logic [2:0]  OFF_TXDATA   = 3'd0;
    localparam logic [2:0]  OFF_STATUS   = 3'd1;
    localparam logic [2:0]  OFF_MTIME    = 3'd2;
    localparam logic [2:0]  OFF_MTIMECMP = 3'd3;
    localparam logic [2:0]  OFF_LED      = 3'd4;
    localparam logic [15:0] BAUD_RELOAD  = 16'(CLK_DIV - 1);

    uart_state_t r_state;
    logic [15:0] r_baud;
    logic [2:0]  r_bitIdx;
    logic [7:0]  r_shift;
    logic        r_uartTx;
    logic [7:0]  r_led;

    logic        w_mmioSel;
    logic [2:0]  w_offset;
    logic        w_mmioWe;
    logic        w_txWrite;
    logic        w_busy;
    logic [31:0] w_mtimeRead;
    logic [31:0] w_mtimecmpRead;
    logic [31:0] w_rdata;
    logic        w_unusedAddr;

    assign w_mmioSel    = bus.cpu_addr[31];
    assign w_offset     = bus.cpu_addr[4:2];
    assign w_mmioWe     = w_mmioSel & bus.cpu_we;
    assign w_busy       = (r_state != UART_IDLE);
    assign w_txWrite    = w_mmioWe && (w_offset == OFF_TXDATA) && !w_busy;
    assign w_unusedAddr = ^{bus.cpu_addr[1:0], bus.cpu_addr[30:RAM_AW+2]};

    assign o_ram_addr  = bus.cpu_addr[RAM_AW+1:2];
    assign o_ram_wdata = bus.cpu_wdata;
    assign o_ram_we    = bus.cpu_we & ~w_mmioSel;
    assign o_uart_tx   = r_uartTx;
    assign o_led       = r_led;

    // Baud counter counts down to 0 and reloads on every bit boundary.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= UART_IDLE;
            r_baud   <= '0;
            r_bitIdx <= '0;
            r_shift  <= '0;
            r_uartTx <= 1'b1;
        end else begin
            case (r_state)
                UART_IDLE: begin
                    if (w_txWrite) begin
                        r_state  <= UART_START;
                        r_baud   <= BAUD_RELOAD;
                        r_bitIdx <= '0;
                        r_shift  <= bus.cpu_wdata[7:0];
                        r_uartTx <= 1'b0;
                    end
                end
                UART_START: begin
                    if (r_baud == '0) begin
                        r_state  <= UART_DATA;
                        r_baud   <= BAUD_RELOAD;
                        r_uartTx <= r_shift[0];
                        r_shift  <= {1'b0, r_shift[7:1]};
                    end else begin
                        r_baud <= r_baud - 16'd1;
                    end
                end
                UART_DATA: begin
                    if (r_baud == '0) begin
                        r_baud <= BAUD_RELOAD;
                        if (r_bitIdx == 3'd7) begin
                            r_state  <= UART_STOP;
                            r_bitIdx <= '0;
                            r_uartTx <= 1'b1;
                        end else begin
                            r_bitIdx <= r_bitIdx + 3'd1;
                            r_uartTx <= r_shift[0];
                            r_shift  <= {1'b0, r_shift[7:1]};
                        end
                    end else begin
                        r_baud <= r_baud - 16'd1;
                    end
                end
                UART_STOP: begin
                    if (r_baud == '0) begin
                        r_state <= UART_IDLE;
                    end else begin
                        r_baud <= r_baud - 16'd1;
                    end
                end
                default: r_state <= UART_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_led <= '0;
        end else if (w_mmioWe && (w_offset == OFF_LED)) begin
            r_led <= bus.cpu_wdata[7:0];
        end
    end

`ifdef MMIO_TIMER_EN
    logic [31:0] r_mtime;
    logic [31:0] r_mtimecmp;
    logic        r_timerIrq;

    // A software write to MTIME takes priority over that cycle's increment.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mtime    <= '0;
            r_mtimecmp <= 32'hFFFF_FFFF;
            r_timerIrq <= 1'b0;
        end else begin
            if (w_mmioWe && (w_offset == OFF_MTIME)) begin
                r_mtime <= bus.cpu_wdata;
            end else begin
                r_mtime <= r_mtime + 32'd1;
            end
            if (w_mmioWe && (w_offset == OFF_MTIMECMP)) begin
                r_mtimecmp <= bus.cpu_wdata;
            end
            r_timerIrq <= (r_mtime >= r_mtimecmp);
        end
    end

    assign w_mtimeRead    = r_mtime;
    assign w_mtimecmpRead = r_mtimecmp;
    assign o_timer_irq    = r_timerIrq;
`else
    assign w_mtimeRead    = '0;
    assign w_mtimecmpRead = '0;
    assign o_timer_irq    = 1'b0;
`endif

    always_comb begin
        w_rdata = '0;
        if (!w_mmioSel) begin
            w_rdata = i_ram_rdata;
        end else begin
            case (w_offset)
                OFF_STATUS:   w_rdata = {30'd0, o_timer_irq, w_busy};
                OFF_MTIME:    w_rdata = w_mtimeRead;
                OFF_MTIMECMP: w_rdata = w_mtimecmpRead;
                OFF_LED:      w_rdata = {24'd0, r_led};
                default:      w_rdata = '0;
            endcase
        end
    end

    assign bus.cpu_rdata = w_rdata;

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed self-checking bench for mmio_bridge with CLK_DIV=4.
// Covers reset, decode, LED/unmapped, UART frames and busy drops, timer (when built) and mid-frame reset.
module tb_mmio_bridge;

    localparam int RAM_AW  = 10;
    localparam int CLK_DIV = 4;

    localparam logic [31:0] A_TXDATA   = 32'h8000_0000;
    localparam logic [31:0] A_STATUS   = 32'h8000_0004;
    localparam logic [31:0] A_MTIME    = 32'h8000_0008;
    localparam logic [31:0] A_MTIMECMP = 32'h8000_000C;
    localparam logic [31:0] A_LED      = 32'h8000_0010;
    localparam logic [31:0] A_UNMAPPED = 32'h8000_001C;

    logic              clk;
    logic              rstN;
    logic [RAM_AW-1:0] ramAddr;
    logic [31:0]       ramWdata;
    logic              ramWe;
    logic [31:0]       ramRdata;
    logic              uartTx;
    logic              timerIrq;
    logic [7:0]        led;

    int assertCount;
    int failCount;

    mmio_bridge_if busIf ();

    mmio_bridge #(
        .RAM_AW (RAM_AW),
        .CLK_DIV(CLK_DIV)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rstN),
        .bus        (busIf.slave),
        .o_ram_addr (ramAddr),
        .o_ram_wdata(ramWdata),
        .o_ram_we   (ramWe),
        .i_ram_rdata(ramRdata),
        .o_uart_tx  (uartTx),
        .o_timer_irq(timerIrq),
        .o_led      (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one store across the next rising edge, then leaves the bus idle on the same address.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
        busIf.cpu_addr  = addr;
        busIf.cpu_wdata = data;
        busIf.cpu_we    = 1'b1;
        @(posedge clk);
        #1;
        busIf.cpu_we = 1'b0;
    endtask

    task automatic test_reset;
        rstN            = 1'b0;
        busIf.cpu_addr  = A_STATUS;
        busIf.cpu_wdata = 32'd0;
        busIf.cpu_we    = 1'b0;
        ramRdata        = 32'd0;
        #12;
        assertCount++;
        if (uartTx !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL reset_uart_tx: got %b expected 1", uartTx);
        end
        assertCount++;
        if (led !== 8'h00) begin
            failCount++;
            $display("[TB] FAIL reset_led: got %h expected 00", led);
        end
        assertCount++;
        if (timerIrq !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_timer_irq: got %b expected 0", timerIrq);
        end
        assertCount++;
        if (busIf.cpu_rdata !== 32'd0) begin
            failCount++;
            $display("[TB] FAIL reset_status: got %h expected 00000000", busIf.cpu_rdata);
        end
        #10;
        rstN = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_decode;
        busIf.cpu_addr  = 32'h0000_0040;
        busIf.cpu_wdata = 32'hDEAD_BEEF;
        busIf.cpu_we    = 1'b1;
        #1;
        assertCount++;
        if (ramWe !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL ram_we_store: got %b expected 1", ramWe);
        end
        assertCount++;
        if (ramAddr !== 10'd16) begin
            failCount++;
            $display("[TB] FAIL ram_addr: got %0d expected 16", ramAddr);
        end
        assertCount++;
        if (ramWdata !== 32'hDEAD_BEEF) begin
            failCount++;
            $display("[TB] FAIL ram_wdata: got %h expected deadbeef", ramWdata);
        end
        @(posedge clk);
        #1;
        busIf.cpu_we = 1'b0;
        ramRdata     = 32'h1357_9BDF;
        #1;
        assertCount++;
        if (busIf.cpu_rdata !== 32'h1357_9BDF) begin
            failCount++;
            $display("[TB] FAIL ram_read: got %h expected 13579bdf", busIf.cpu_rdata);
        end
        busIf.cpu_addr = A_STATUS;
        busIf.cpu_we   = 1'b1;
        #1;
        assertCount++;
        if (ramWe !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL ram_we_mmio: got %b expected 0", ramWe);
        end
        @(posedge clk);
        #1;
        busIf.cpu_we = 1'b0;
    endtask

    task automatic test_led_unmapped;
        applyStimulus(A_LED, 32'h1234_56C3);
        assertCount++;
        if (led !== 8'hC3) begin
            failCount++;
            $display("[TB] FAIL led_value: got %h expected c3", led);
        end
        assertCount++;
        if (busIf.cpu_rdata !== 32'h0000_00C3) begin
            failCount++;
            $display("[TB] FAIL led_readback: got %h expected 000000c3", busIf.cpu_rdata);
        end
        applyStimulus(A_UNMAPPED, 32'hFFFF_FFFF);
        assertCount++;
        if (busIf.cpu_rdata !== 32'd0) begin
            failCount++;
            $display("[TB] FAIL unmapped_read: got %h expected 00000000", busIf.cpu_rdata);
        end
        assertCount++;
        if (led !== 8'hC3) begin
            failCount++;
            $display("[TB] FAIL unmapped_led: got %h expected c3", led);
        end
        assertCount++;
        if (uartTx !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL unmapped_uart_tx: got %b expected 1", uartTx);
        end
        busIf.cpu_addr = A_TXDATA;
        #1;
        assertCount++;
        if (busIf.cpu_rdata !== 32'd0) begin
            failCount++;
            $display("[TB] FAIL txdata_read: got %h expected 00000000", busIf.cpu_rdata);
        end
    endtask

    task automatic test_uart_frame;
        logic [9:0] frame;
        frame = {1'b1, 8'hA5, 1'b0};
        applyStimulus(A_TXDATA, 32'h0000_00A5);
        busIf.cpu_addr = A_STATUS;
        #1;
        for (int k = 0; k < 40; k++) begin
            assertCount++;
            if (uartTx !== frame[k/4]) begin
                failCount++;
                $display("[TB] FAIL frame_a5_tx cycle %0d: got %b expected %b", k, uartTx, frame[k/4]);
            end
            assertCount++;
            if (busIf.cpu_rdata[0] !== 1'b1) begin
                failCount++;
                $display("[TB] FAIL frame_a5_busy cycle %0d: got %b expected 1", k, busIf.cpu_rdata[0]);
            end
            @(posedge clk);
            #2;
        end
        assertCount++;
        if (uartTx !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL frame_a5_idle_tx: got %b expected 1", uartTx);
        end
        assertCount++;
        if (busIf.cpu_rdata[0] !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL frame_a5_idle_busy: got %b expected 0", busIf.cpu_rdata[0]);
        end
    endtask

    // Writes during the frame and in the final STOP cycle must both be dropped.
    task automatic test_uart_busy_drop;
        logic [9:0] frame;
        frame = {1'b1, 8'hA5, 1'b0};
        applyStimulus(A_TXDATA, 32'h0000_00A5);
        busIf.cpu_addr = A_STATUS;
        #1;
        for (int k = 0; k < 40; k++) begin
            assertCount++;
            if (uartTx !== frame[k/4]) begin
                failCount++;
                $display("[TB] FAIL drop_tx cycle %0d: got %b expected %b", k, uartTx, frame[k/4]);
            end
            if (k == 10 || k == 39) begin
                busIf.cpu_addr  = A_TXDATA;
                busIf.cpu_wdata = (k == 10) ? 32'h0000_005A : 32'h0000_003C;
                busIf.cpu_we    = 1'b1;
            end
            @(posedge clk);
            #1;
            busIf.cpu_we   = 1'b0;
            busIf.cpu_addr = A_STATUS;
            #1;
        end
        assertCount++;
        if (uartTx !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL drop_stop_write_tx: got %b expected 1", uartTx);
        end
        assertCount++;
        if (busIf.cpu_rdata[0] !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL drop_stop_write_busy: got %b expected 0", busIf.cpu_rdata[0]);
        end
    endtask

    task automatic test_back_to_back;
        logic [9:0] frame;
        frame = {1'b1, 8'h3C, 1'b0};
        applyStimulus(A_TXDATA, 32'h0000_003C);
        busIf.cpu_addr = A_STATUS;
        #1;
        for (int k = 0; k < 40; k++) begin
            assertCount++;
            if (uartTx !== frame[k/4]) begin
                failCount++;
                $display("[TB] FAIL frame_3c_tx cycle %0d: got %b expected %b", k, uartTx, frame[k/4]);
            end
            if (k == 0) begin
                assertCount++;
                if (busIf.cpu_rdata[0] !== 1'b1) begin
                    failCount++;
                    $display("[TB] FAIL frame_3c_busy: got %b expected 1", busIf.cpu_rdata[0]);
                end
            end
            @(posedge clk);
            #2;
        end
        assertCount++;
        if (busIf.cpu_rdata[0] !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL frame_3c_idle_busy: got %b expected 0", busIf.cpu_rdata[0]);
        end
    endtask

`ifdef MMIO_TIMER_EN
    task automatic test_timer;
        applyStimulus(A_MTIME, 32'hFFFF_FFF0);
        applyStimulus(A_MTIMECMP, 32'hFFFF_FFF8);
        assertCount++;
        if (busIf.cpu_rdata !== 32'hFFFF_FFF8) begin
            failCount++;
            $display("[TB] FAIL mtimecmp_readback: got %h expected fffffff8", busIf.cpu_rdata);
        end
        busIf.cpu_addr = A_MTIME;
        #1;
        assertCount++;
        if (busIf.cpu_rdata !== 32'hFFFF_FFF1) begin
            failCount++;
            $display("[TB] FAIL mtime_after_load: got %h expected fffffff1", busIf.cpu_rdata);
        end
        repeat (7) @(posedge clk);
        #1;
        assertCount++;
        if (busIf.cpu_rdata !== 32'hFFFF_FFF8) begin
            failCount++;
            $display("[TB] FAIL mtime_at_cmp: got %h expected fffffff8", busIf.cpu_rdata);
        end
        assertCount++;
        if (timerIrq !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL irq_lag: got %b expected 0", timerIrq);
        end
        @(posedge clk);
        #1;
        assertCount++;
        if (timerIrq !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL irq_rise: got %b expected 1", timerIrq);
        end
        busIf.cpu_addr = A_STATUS;
        #1;
        assertCount++;
        if (busIf.cpu_rdata !== 32'h0000_0002) begin
            failCount++;
            $display("[TB] FAIL status_irq: got %h expected 00000002", busIf.cpu_rdata);
        end
        busIf.cpu_addr = A_MTIME;
        repeat (7) @(posedge clk);
        #1;
        assertCount++;
        if (busIf.cpu_rdata !== 32'd0) begin
            failCount++;
            $display("[TB] FAIL mtime_wrap: got %h expected 00000000", busIf.cpu_rdata);
        end
        assertCount++;
        if (timerIrq !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL irq_hold_at_wrap: got %b expected 1", timerIrq);
        end
        @(posedge clk);
        #1;
        assertCount++;
        if (timerIrq !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL irq_clear_after_wrap: got %b expected 0", timerIrq);
        end
    endtask
`else
    task automatic test_timer;
        applyStimulus(A_MTIME, 32'hFFFF_FFF0);
        assertCount++;
        if (busIf.cpu_rdata !== 32'd0) begin
            failCount++;
            $display("[TB] FAIL mtime_disabled: got %h expected 00000000", busIf.cpu_rdata);
        end
        applyStimulus(A_MTIMECMP, 32'h0000_0000);
        assertCount++;
        if (busIf.cpu_rdata !== 32'd0) begin
            failCount++;
            $display("[TB] FAIL mtimecmp_disabled: got %h expected 00000000", busIf.cpu_rdata);
        end
        repeat (3) @(posedge clk);
        #1;
        assertCount++;
        if (timerIrq !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL irq_disabled: got %b expected 0", timerIrq);
        end
        busIf.cpu_addr = A_STATUS;
        #1;
        assertCount++;
        if (busIf.cpu_rdata !== 32'd0) begin
            failCount++;
            $display("[TB] FAIL status_disabled: got %h expected 00000000", busIf.cpu_rdata);
        end
    endtask
`endif

    // Byte 0x00 keeps the line low through DATA, so the asynchronous return to 1 is visible.
    task automatic test_reset_mid_frame;
        applyStimulus(A_TXDATA, 32'h0000_0000);
        busIf.cpu_addr = A_STATUS;
        repeat (17) @(posedge clk);
        #1;
        assertCount++;
        if (uartTx !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL midframe_bit3_tx: got %b expected 0", uartTx);
        end
        rstN = 1'b0;
        #1;
        assertCount++;
        if (uartTx !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL midframe_async_tx: got %b expected 1", uartTx);
        end
        assertCount++;
        if (led !== 8'h00) begin
            failCount++;
            $display("[TB] FAIL midframe_led: got %h expected 00", led);
        end
        #2;
        rstN = 1'b1;
        @(posedge clk);
        #1;
        assertCount++;
        if (busIf.cpu_rdata[0] !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL midframe_busy: got %b expected 0", busIf.cpu_rdata[0]);
        end
        for (int k = 0; k < 8; k++) begin
            assertCount++;
            if (uartTx !== 1'b1) begin
                failCount++;
                $display("[TB] FAIL midframe_no_resume cycle %0d: got %b expected 1", k, uartTx);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        test_reset();
        test_decode();
        test_led_unmapped();
        test_uart_frame();
        test_uart_busy_drop();
        test_back_to_back();
        test_timer();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
